// File: rtl/cn_stream_pkg.sv
// Shared definitions for the host-to-core job stream stages.
// The keep-mask helper covers byte-lane masks up to KEEP_MAX_W lanes wide.
package cn_stream_pkg;

  localparam int BYTE_W     = 8;
  localparam int KEEP_MAX_W = 128;

  // Low nwords*in_w/8 bits set, clamped to the out_w/8 lanes of a block.
  function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int nwords,
                                                      input int in_w,
                                                      input int out_w);
    logic [KEEP_MAX_W-1:0] mask;
    int                    nbytes;
    nbytes = nwords * (in_w / BYTE_W);
    if (nbytes > out_w / BYTE_W) begin
      nbytes = out_w / BYTE_W;
    end else begin
      nbytes = nbytes;
    end
    mask = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      mask[i] = (i < nbytes) ? 1'b1 : 1'b0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs IN_W-bit stream words into OUT_W-bit blocks, first word in lane 0.
// Emits a byte-keep mask and a last flag; does no byte reordering.
module word_packer
  import cn_stream_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic [OUT_W/8-1:0] m_keep,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready
);

  localparam int N      = OUT_W / IN_W;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int KEEP_W = OUT_W / BYTE_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((OUT_W % IN_W) != 0 || (IN_W % BYTE_W) != 0 || KEEP_W > KEEP_MAX_W) begin : g_bad_width
    $error("word_packer: OUT_W must be a multiple of IN_W, IN_W a multiple of 8");
  end

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [OUT_W-1:0]  acc_r;
  logic [OUT_W-1:0]  acc_nxt_s;
  logic [OUT_W-1:0]  merged_s;
  logic [OUT_W-1:0]  m_data_r;
  logic [KEEP_W-1:0] m_keep_r;
  logic              m_valid_r;
  logic              m_last_r;
  logic              accept_s;
  logic              complete_s;

  assign s_ready    = rst_n && (!m_valid_r || m_ready);
  assign accept_s   = s_valid && s_ready;
  assign complete_s = accept_s && ((cnt_r == LAST_CNT) || s_last);

  assign m_data  = m_data_r;
  assign m_keep  = m_keep_r;
  assign m_valid = m_valid_r;
  assign m_last  = m_last_r;

  // Accumulator lanes below cnt, the incoming word at cnt, zero above.
  always_comb begin
    merged_s = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(cnt_r)) begin
        merged_s[k*IN_W +: IN_W] = acc_r[k*IN_W +: IN_W];
      end else if (k == int'(cnt_r)) begin
        merged_s[k*IN_W +: IN_W] = s_data;
      end else begin
        merged_s[k*IN_W +: IN_W] = '0;
      end
    end
  end

  // Next word counter and accumulator contents.
  always_comb begin
    cnt_nxt_s = cnt_r;
    acc_nxt_s = acc_r;
    if (complete_s) begin
      cnt_nxt_s = '0;
      acc_nxt_s = '0;
    end else if (accept_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
      acc_nxt_s = merged_s;
    end else begin
      cnt_nxt_s = cnt_r;
      acc_nxt_s = acc_r;
    end
  end

  // State and output registers; a completion overrides the drain of the previous block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      acc_r     <= '0;
      m_data_r  <= '0;
      m_keep_r  <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      acc_r <= acc_nxt_s;
      if (complete_s) begin
        m_data_r  <= merged_s;
        m_keep_r  <= KEEP_W'(keep_mask(int'(cnt_r) + 1, IN_W, OUT_W));
        m_last_r  <= s_last;
        m_valid_r <= 1'b1;
      end else if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: queue-based block model plus literal expectations.
module tb_word_packer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 128;
  localparam int N     = OUT_W / IN_W;
  localparam int KW    = OUT_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IN_W-1:0]   s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [OUT_W-1:0]  m_data;
  logic [KW-1:0]     m_keep;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b0;

  always #5 clk = ~clk;

  word_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [KW-1:0]    k;
    logic             l;
  } blk_t;

  blk_t            exp_q[$];
  blk_t            got_q[$];
  logic [IN_W-1:0] part_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  bit              armed    = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Behavioural model: words accumulate per message; a block closes at N words or on last.
  initial begin
    blk_t             e;
    blk_t             a;
    bit               hold = 1'b0;
    logic [OUT_W-1:0] hd;
    logic [KW-1:0]    hk;
    logic             hl;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        part_q.delete();
        exp_q.delete();
        hold = 1'b0;
      end else if (armed) begin
        check("s_ready_rule", 128'(s_ready), 128'(!m_valid || m_ready));
        if (hold) begin
          check("hold_valid", 128'(m_valid), 128'(1'b1));
          check("hold_data", m_data, hd);
          check("hold_keep", 128'(m_keep), 128'(hk));
          check("hold_last", 128'(m_last), 128'(hl));
        end
        if (m_valid && m_ready) begin
          check("block_expected", 128'(exp_q.size() != 0), 128'(1'b1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("blk_data", m_data, e.d);
            check("blk_keep", 128'(m_keep), 128'(e.k));
            check("blk_last", 128'(m_last), 128'(e.l));
          end
          a.d = m_data; a.k = m_keep; a.l = m_last;
          got_q.push_back(a);
        end
        hold = m_valid && !m_ready;
        hd = m_data; hk = m_keep; hl = m_last;
        if (s_valid && s_ready) begin
          part_q.push_back(s_data);
          if (part_q.size() == N || s_last) begin
            e.d = '0;
            for (int k = 0; k < part_q.size(); k++) e.d |= OUT_W'(part_q[k]) << (IN_W * k);
            e.k = KW'((1 << (part_q.size() * (IN_W / 8))) - 1);
            e.l = s_last;
            exp_q.push_back(e);
            part_q.delete();
          end
        end
      end
    end
  end

  task automatic send_word(input logic [IN_W-1:0] d, input logic l);
    bit ok;
    int b = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    do begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1; b++;
    end while (!ok && b < 200);
    check("send_accepted", 128'(ok), 128'(1'b1));
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    s_valid = 1'b0; m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && b < 100) begin
      @(posedge clk); #1; b++;
    end
    check("drain_done", 128'(exp_q.size() + int'(m_valid)), 128'(0));
  endtask

  initial begin
    // Reset held with s_valid asserted
    rst_n = 1'b0; s_valid = 1'b1; s_data = 32'hAAAA5555; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_s_ready", 128'(s_ready), 128'(1'b0));
    end
    check("rst_m_valid", 128'(m_valid), 128'(1'b0));
    check("rst_m_data", m_data, 128'h0);
    check("rst_m_keep", 128'(m_keep), 128'h0);
    check("rst_m_last", 128'(m_last), 128'(1'b0));
    s_valid = 1'b0; rst_n = 1'b1; armed = 1'b1;

    // Full block with last on word 4, one-cycle latency
    send_word(32'h03020100, 1'b0);
    send_word(32'h07060504, 1'b0);
    send_word(32'h0B0A0908, 1'b0);
    send_word(32'h0F0E0D0C, 1'b1);
    check("t2_valid", 128'(m_valid), 128'(1'b1));
    check("t2_data", m_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    check("t2_keep", 128'(m_keep), 128'hFFFF);
    check("t2_last", 128'(m_last), 128'(1'b1));
    @(posedge clk); #1;
    check("t2_valid_drop", 128'(m_valid), 128'(1'b0));

    // 76-byte blob: 19 words back to back
    got_q.delete();
    for (int i = 1; i <= 19; i++) send_word(32'(i), (i == 19) ? 1'b1 : 1'b0);
    drain();
    check("t3_nblocks", 128'(got_q.size()), 128'(5));
    if (got_q.size() == 5) begin
      check("t3_b5_data", got_q[4].d, 128'h00000000_00000013_00000012_00000011);
      check("t3_b5_keep", 128'(got_q[4].k), 128'h0FFF);
      check("t3_b5_last", 128'(got_q[4].l), 128'(1'b1));
      check("t3_b1_keep", 128'(got_q[0].k), 128'hFFFF);
      check("t3_b4_last", 128'(got_q[3].l), 128'(1'b0));
    end

    // Backpressure: block 1 held for 10 cycles while word 5 waits
    got_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h100 + 32'(i), 1'b0);
    s_valid = 1'b1; s_data = 32'h104;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_s_ready_low", 128'(s_ready), 128'(1'b0));
      check("t4_data_stable", m_data, 128'h00000103_00000102_00000101_00000100);
    end
    m_ready = 1'b1;
    send_word(32'h104, 1'b0);
    send_word(32'h105, 1'b0);
    send_word(32'h106, 1'b0);
    send_word(32'h107, 1'b1);
    drain();
    check("t4_nblocks", 128'(got_q.size()), 128'(2));

    // Single-word message, then the next message restarts at lane 0
    got_q.delete();
    send_word(32'hDEADBEEF, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) send_word(32'h11110000 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
    drain();
    check("t5_nblocks", 128'(got_q.size()), 128'(2));
    if (got_q.size() == 2) begin
      check("t5_data", got_q[0].d, 128'h00000000_00000000_00000000_DEADBEEF);
      check("t5_keep", 128'(got_q[0].k), 128'h000F);
      check("t5_last", 128'(got_q[0].l), 128'(1'b1));
      check("t5_next", got_q[1].d, 128'h11110003_11110002_11110001_11110000);
    end

    // Reset mid-block discards stale words
    got_q.delete();
    send_word(32'hBAD00001, 1'b0);
    send_word(32'hBAD00002, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_word(32'h60000000 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
    drain();
    check("t6_nblocks", 128'(got_q.size()), 128'(1));
    if (got_q.size() == 1)
      check("t6_data", got_q[0].d, 128'h60000003_60000002_60000001_60000000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      s_valid = ($urandom % 4) != 0;
      s_data  = $urandom;
      s_last  = ($urandom % 5) == 0;
      m_ready = ($urandom % 3) != 0;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    send_word(32'h5A5A5A5A, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
Stream deserializer in front of the byte-reversal stage on the host-to-core job path. Accumulates IN_W-bit host bus words (e.g. the 76-byte job blob) into OUT_W-bit blocks with valid/ready handshakes on both sides. Emits a byte-keep mask and a last flag. The parent instantiates the byte-reversal stage on m_data; this block does no reordering.

Parameters:
IN_W, 32, input word width in bits; multiple of 8
OUT_W, 128, output block width in bits; integer multiple of IN_W

Ports:
clk  input  1  single clock; all logic rising-edge
rst_n  input  1  synchronous reset, active-low
s_data  input  IN_W  input word
s_valid  input  1  input word valid
s_last  input  1  final word of the message
s_ready  output  1  input word accepted when s_valid && s_ready
m_data  output  OUT_W  assembled block
m_keep  output  OUT_W/8  byte-valid mask; bit i covers m_data[8i+7:8i]
m_valid  output  1  block valid
m_last  output  1  block contains the message's final word
m_ready  input  1  downstream accepts the block when m_valid && m_ready

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): m_valid=0, m_data=0, m_keep=0, m_last=0, word counter=0, accumulator=0. Any partial block in progress is discarded. s_ready is 0 while rst_n=0.
- Word count: N = OUT_W/IN_W. Counter cnt runs 0..N-1. Word k of a block lands in accumulator bits [k*IN_W +: IN_W], so the first word goes to the least-significant lane.
- Handshake: s_ready = rst_n && (!m_valid || m_ready). This is combinational from m_ready only and never depends on s_valid, s_data or s_last. m_valid, m_data, m_keep and m_last are registered and held stable until accepted.
- Accepting a non-final word (cnt<N-1 and s_last=0): the word is written into the accumulator and cnt increments. Output registers are unchanged.
- Completing a block (accepted word with cnt==N-1 or s_last=1): on the same edge, m_data gets the accumulator merged with the new word.
  - Lanes above cnt are forced to 0.
  - m_keep has the low (cnt+1)*IN_W/8 bits set.
  - m_last = s_last, m_valid = 1.
  - cnt returns to 0 and the accumulator clears.
- Latency: one cycle from acceptance of the completing word to m_valid=1.
- Output acceptance: on m_valid && m_ready with no new completion that edge, m_valid goes to 0. If a completion happens on the same edge, m_valid stays 1 with the new contents. This gives sustained throughput of 1 word/clk.
- Full message (s_last on word N-1): m_keep is all ones and m_last=1.
- Degenerate case N=1: every accepted word completes a block. This is a registered pass-through with m_keep all ones.
- s_valid=0: no state change except the output drain.
- s_last outside a handshake is ignored.
- Width rules: the counter is $clog2(N) bits, minimum 1. m_keep lanes are computed from cnt with no arithmetic overflow.
- Elaboration error if OUT_W % IN_W != 0 or IN_W % 8 != 0.

Decomposition:
- Shared package cn_stream_pkg:
  - BYTE_W=8.
  - Function keep_mask(nwords, IN_W, OUT_W) returning the OUT_W/8-bit mask.
  - Reusable by other stream stages on the job path.
- Local constants N and CNT_W are derived in-module.
- No sub-module: counter, accumulator and output register are one flat block. The byte reversal stays a separate instance in the parent.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles while driving s_valid=1 -> s_ready=0, m_valid=0, m_data=0, m_keep=0x0000, m_last=0.
2. Full block, m_ready=1: send words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with s_last on the 4th -> one cycle later m_data=0x0F0E0D0C_0B0A0908_07060504_03020100, m_keep=0xFFFF, m_last=1, m_valid=1 for one cycle.
3. 76-byte blob (19 words 0x00000001..0x00000013, s_last on word 19), back-to-back -> 5 blocks. Block 5 has m_data low 96 bits = 0x00000013_00000012_00000011, upper 32 bits = 0, m_keep=0x0FFF, m_last=1. Blocks 1-4 have m_last=0 and m_keep=0xFFFF.
4. Backpressure: m_ready=0 after block 1 completes -> s_ready=0 and m_data stable for 10 cycles. When m_ready=1, the next word is accepted on that same edge, with no loss or duplication (compare the output stream against a scoreboard).
5. s_last on the first word 0xDEADBEEF -> m_data=0x...0000DEADBEEF (upper 96 bits zero), m_keep=0x000F, m_last=1. The next message starts at lane 0.
6. Reset mid-block after 2 words, then a fresh 4-word message -> no block emitted for the stale words. The first output has m_data equal to the 4 new words only.
